// File: rtl/fft_pkg.sv
// Shared constants for the N=128 radix-2 MDC FFT pipeline.
//   FFT_DW      : default real/imag component width
//   FFT_N       : transform size
//   FFT_STAGES  : number of radix-2 stages (log2 of FFT_N)
//   stage_depth : commutator delay used after butterfly stage i (64, 32, ..., 1)
package fft_pkg;

    localparam int FFT_DW     = 16;
    localparam int FFT_N      = 128;
    localparam int FFT_STAGES = 7;

    function automatic int stage_depth(input int stage);
        return (FFT_N / 2) >> stage;
    endfunction

endpackage

// File: rtl/mdc_commutator_if.sv
// Bundle of the two-lane complex stream entering and leaving a commutator.
//   sync, in_valid, in_a_*, in_b_*  : upstream butterfly -> commutator
//   out_valid, out_a_*, out_b_*     : commutator -> downstream butterfly
// The master modport is the side that feeds the commutator; the slave modport
// is the commutator itself.
interface mdc_commutator_if
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW
);

    logic          sync;
    logic          in_valid;
    logic [DW-1:0] in_a_re;
    logic [DW-1:0] in_a_im;
    logic [DW-1:0] in_b_re;
    logic [DW-1:0] in_b_im;
    logic          out_valid;
    logic [DW-1:0] out_a_re;
    logic [DW-1:0] out_a_im;
    logic [DW-1:0] out_b_re;
    logic [DW-1:0] out_b_im;

    modport master (
        output sync, in_valid, in_a_re, in_a_im, in_b_re, in_b_im,
        input  out_valid, out_a_re, out_a_im, out_b_re, out_b_im
    );

    modport slave (
        input  sync, in_valid, in_a_re, in_a_im, in_b_re, in_b_im,
        output out_valid, out_a_re, out_a_im, out_b_re, out_b_im
    );

endinterface

// File: rtl/cplx_delay_line.sv
// Enable-gated complex shift register of DEPTH stages.
//   clk, rst   : clock, asynchronous active-low reset (clears every stage to 0)
//   en_i       : shift one position when high, hold otherwise
//   re_i, im_i : sample entering stage 0
//   re_o, im_o : oldest stage, i.e. the sample accepted DEPTH enables ago
module cplx_delay_line
    import fft_pkg::*;
#(
    parameter int DW    = FFT_DW,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [DW-1:0] re_i,
    input  logic [DW-1:0] im_i,
    output logic [DW-1:0] re_o,
    output logic [DW-1:0] im_o
);

    logic [DW-1:0] re_q  [DEPTH];
    logic [DW-1:0] im_q  [DEPTH];
    logic [DW-1:0] re_in [DEPTH];
    logic [DW-1:0] im_in [DEPTH];

    // Each stage loads from its predecessor; stage 0 loads the new sample.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign re_in[gi] = re_i;
                assign im_in[gi] = im_i;
            end else begin : g_tail
                assign re_in[gi] = re_q[gi-1];
                assign im_in[gi] = im_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (en_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                re_q[i] <= re_in[i];
                im_q[i] <= im_in[i];
            end
        end
    end

    assign re_o = re_q[DEPTH-1];
    assign im_o = im_q[DEPTH-1];

endmodule

// File: rtl/mdc_commutator.sv
// Delay-switch-delay commutator between two radix-2 MDC butterfly stages.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of the stream bundle (sync/in_valid/in_a/in_b in,
//              registered out_valid/out_a/out_b out)
// Lane b is delayed by DEPTH accepted samples, the switch swaps lanes when bit
// log2(DEPTH) of the frame index is set, and the upper lane is then delayed by
// DEPTH so that samples DEPTH apart leave together.
module mdc_commutator
    import fft_pkg::*;
#(
    parameter int DW    = FFT_DW,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    mdc_commutator_if.slave bus
);

    localparam int PW = $clog2(DEPTH) + 1;   // phase counter, wraps mod 2*DEPTH
    localparam int FW = $clog2(DEPTH + 1);   // fill counter, saturates at DEPTH

    logic [PW-1:0] phase_q, phase_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [PW-1:0] idx;
    logic [FW-1:0] fill_cur;
    logic          sw;
    logic          primed;

    logic [DW-1:0] bd_re, bd_im;
    logic [DW-1:0] top_re, top_im;
    logic [DW-1:0] bot_re, bot_im;
    logic [DW-1:0] ua_re, ua_im;

    logic          out_valid_q;
    logic [DW-1:0] out_a_re_q, out_a_im_q, out_b_re_q, out_b_im_q;

    // A sync sample is index 0 of a new frame, so the counters are viewed as
    // already restarted when deciding this sample's switch position and
    // validity. Data already in the delay lines is simply never flagged.
    always_comb begin
        idx      = bus.sync ? '0 : phase_q;
        fill_cur = bus.sync ? '0 : fill_q;
        sw       = idx[PW-1];
        primed   = (fill_cur == FW'(DEPTH));
        phase_d  = phase_q;
        fill_d   = fill_q;
        if (bus.in_valid) begin
            phase_d = idx + 1'b1;
            fill_d  = primed ? fill_cur : fill_cur + 1'b1;
        end
    end

    always_comb begin
        top_re = sw ? bd_re : bus.in_a_re;
        top_im = sw ? bd_im : bus.in_a_im;
        bot_re = sw ? bus.in_a_re : bd_re;
        bot_im = sw ? bus.in_a_im : bd_im;
    end

    cplx_delay_line #(.DW(DW), .DEPTH(DEPTH)) u_lower (
        .clk  (clk),
        .rst  (rst),
        .en_i (bus.in_valid),
        .re_i (bus.in_b_re),
        .im_i (bus.in_b_im),
        .re_o (bd_re),
        .im_o (bd_im)
    );

    cplx_delay_line #(.DW(DW), .DEPTH(DEPTH)) u_upper (
        .clk  (clk),
        .rst  (rst),
        .en_i (bus.in_valid),
        .re_i (top_re),
        .im_i (top_im),
        .re_o (ua_re),
        .im_o (ua_im)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q     <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_a_re_q  <= '0;
            out_a_im_q  <= '0;
            out_b_re_q  <= '0;
            out_b_im_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            fill_q      <= fill_d;
            out_valid_q <= bus.in_valid & primed;
            // Data registers only move on accepted samples so a stall holds them.
            if (bus.in_valid) begin
                out_a_re_q <= ua_re;
                out_a_im_q <= ua_im;
                out_b_re_q <= bot_re;
                out_b_im_q <= bot_im;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_a_re  = out_a_re_q;
    assign bus.out_a_im  = out_a_im_q;
    assign bus.out_b_re  = out_b_re_q;
    assign bus.out_b_im  = out_b_im_q;

endmodule

// File: tb/tb_mdc_commutator.sv
// Self-checking bench for mdc_commutator at DEPTH 4, 1 and 64. A reference
// model keeps the full history of lane b and of the switched upper lane per
// accepted sample and derives every expected output from the delay/switch rules.
module tb_mdc_commutator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdc_commutator_if #(.DW(16)) bus0 ();
    mdc_commutator_if #(.DW(16)) bus1 ();
    mdc_commutator_if #(.DW(16)) bus2 ();

    mdc_commutator #(.DW(16), .DEPTH(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mdc_commutator #(.DW(16), .DEPTH(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mdc_commutator #(.DW(16), .DEPTH(64)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, one slot per DUT
    int          depth_m [3] = '{4, 1, 64};
    int          gc      [3];              // accepted samples since reset
    int          fc      [3];              // accepted samples since frame start
    logic [31:0] bh      [3][4096];        // lane b history {re,im}
    logic [31:0] th      [3][4096];        // switched upper-lane history
    logic [31:0] exp_a   [3];
    logic [31:0] exp_b   [3];
    bit          last_ok [3];
    bit          exp_v;
    bit          chk_data;
    logic        obs_v;
    logic [31:0] obs_a, obs_b;

    task automatic model_reset();
        for (int w = 0; w < 3; w++) begin
            gc[w] = 0; fc[w] = 0;
            exp_a[w] = '0; exp_b[w] = '0;
            last_ok[w] = 1'b0;
        end
    endtask

    task automatic idle_all();
        bus0.in_valid = 1'b0; bus0.sync = 1'b0;
        bus1.in_valid = 1'b0; bus1.sync = 1'b0;
        bus2.in_valid = 1'b0; bus2.sync = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Drive one cycle on DUT w (called at a negedge), let it clock, sample the
    // outputs at the following negedge and advance the model.
    task automatic apply(input int w, input bit v, input bit sy,
                         input logic [31:0] a, input logic [31:0] b);
        int d, g, n;
        bit s;
        logic [31:0] bd, top, bot;
        case (w)
            0: begin bus0.in_valid = v; bus0.sync = sy;
                     bus0.in_a_re = a[31:16]; bus0.in_a_im = a[15:0];
                     bus0.in_b_re = b[31:16]; bus0.in_b_im = b[15:0]; end
            1: begin bus1.in_valid = v; bus1.sync = sy;
                     bus1.in_a_re = a[31:16]; bus1.in_a_im = a[15:0];
                     bus1.in_b_re = b[31:16]; bus1.in_b_im = b[15:0]; end
            default: begin bus2.in_valid = v; bus2.sync = sy;
                     bus2.in_a_re = a[31:16]; bus2.in_a_im = a[15:0];
                     bus2.in_b_re = b[31:16]; bus2.in_b_im = b[15:0]; end
        endcase
        @(posedge clk);
        @(negedge clk);
        case (w)
            0: begin obs_v = bus0.out_valid; obs_a = {bus0.out_a_re, bus0.out_a_im};
                     obs_b = {bus0.out_b_re, bus0.out_b_im}; end
            1: begin obs_v = bus1.out_valid; obs_a = {bus1.out_a_re, bus1.out_a_im};
                     obs_b = {bus1.out_b_re, bus1.out_b_im}; end
            default: begin obs_v = bus2.out_valid; obs_a = {bus2.out_a_re, bus2.out_a_im};
                     obs_b = {bus2.out_b_re, bus2.out_b_im}; end
        endcase
        idle_all();
        d = depth_m[w];
        if (v) begin
            g   = gc[w];
            n   = sy ? 0 : fc[w];
            bd  = (g >= d) ? bh[w][(g - d) % 4096] : 32'h0;
            s   = ((n / d) % 2) == 1;
            top = s ? bd : a;
            bot = s ? a : bd;
            exp_a[w] = (g >= d) ? th[w][(g - d) % 4096] : 32'h0;
            exp_b[w] = bot;
            bh[w][g % 4096] = b;
            th[w][g % 4096] = top;
            gc[w] = g + 1;
            fc[w] = n + 1;
            exp_v      = (n >= d);
            chk_data   = exp_v;
            last_ok[w] = exp_v;
        end else begin
            exp_v    = 1'b0;
            chk_data = last_ok[w];   // stalled: last valid pair must be held
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_vec++;
        if ({bus0.out_valid, bus0.out_a_re, bus0.out_a_im, bus0.out_b_re, bus0.out_b_im} !== 65'h0) begin
            n_err++; $display("FAIL reset_dut0: got %h want 0", {bus0.out_a_re, bus0.out_a_im, bus0.out_b_re, bus0.out_b_im});
        end
        n_vec++;
        if ({bus1.out_valid, bus1.out_a_re, bus1.out_a_im, bus1.out_b_re, bus1.out_b_im} !== 65'h0) begin
            n_err++; $display("FAIL reset_dut1: got %h want 0", {bus1.out_a_re, bus1.out_a_im, bus1.out_b_re, bus1.out_b_im});
        end
        n_vec++;
        if ({bus2.out_valid, bus2.out_a_re, bus2.out_a_im, bus2.out_b_re, bus2.out_b_im} !== 65'h0) begin
            n_err++; $display("FAIL reset_dut2: got %h want 0", {bus2.out_a_re, bus2.out_a_im, bus2.out_b_re, bus2.out_b_im});
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // DEPTH=4 ramp a_n=n, b_n=100+n, optionally with a 3-cycle stall before n=stall_at
    task automatic test_stream(input string tag, input int stall_at, input bit with_rst);
        int tbl_a [12] = '{0, 1, 2, 3, 100, 101, 102, 103, 8, 9, 10, 11};
        int tbl_b [12] = '{4, 5, 6, 7, 104, 105, 106, 107, 12, 13, 14, 15};
        int n = 0;
        int stalls = 0;
        bit v;
        if (with_rst) do_reset();
        while (n < 16) begin
            v = !(n == stall_at && stalls < 3);
            if (!v) stalls++;
            apply(0, v, 1'b0, {16'(n), 16'(500 + n)}, {16'(100 + n), 16'(600 + n)});
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL %s valid n=%0d: got %b want %b", tag, n, obs_v, exp_v);
            end
            if (chk_data) begin
                n_vec++;
                if ({obs_a, obs_b} !== {exp_a[0], exp_b[0]}) begin
                    n_err++; $display("FAIL %s data n=%0d: got %h %h want %h %h", tag, n, obs_a, obs_b, exp_a[0], exp_b[0]);
                end
            end
            if (v && n >= 4) begin
                n_vec++;
                if ({obs_a[31:16], obs_b[31:16]} !== {16'(tbl_a[n-4]), 16'(tbl_b[n-4])}) begin
                    n_err++; $display("FAIL %s table n=%0d: got (%0d,%0d) want (%0d,%0d)", tag, n, obs_a[31:16], obs_b[31:16], tbl_a[n-4], tbl_b[n-4]);
                end
            end
            if (v) n++;
        end
    endtask

    task automatic test_sync();
        do_reset();
        for (int n = 0; n < 20; n++) begin
            apply(0, 1'b1, n == 10, {16'(n), 16'(700 + n)}, {16'(100 + n), 16'(800 + n)});
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL sync valid n=%0d: got %b want %b", n, obs_v, exp_v);
            end
            if (chk_data) begin
                n_vec++;
                if ({obs_a, obs_b} !== {exp_a[0], exp_b[0]}) begin
                    n_err++; $display("FAIL sync data n=%0d: got %h %h want %h %h", n, obs_a, obs_b, exp_a[0], exp_b[0]);
                end
            end
            if (n == 14) begin
                n_vec++;
                if ({obs_v, obs_a[31:16], obs_b[31:16]} !== {1'b1, 16'd10, 16'd14}) begin
                    n_err++; $display("FAIL sync restart: got %b (%0d,%0d) want 1 (10,14)", obs_v, obs_a[31:16], obs_b[31:16]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int n = 0; n < 7; n++)
            apply(0, 1'b1, 1'b0, {16'(n), 16'(n)}, {16'(100 + n), 16'(n)});
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({bus0.out_valid, bus0.out_a_re, bus0.out_a_im, bus0.out_b_re, bus0.out_b_im} !== 65'h0) begin
            n_err++; $display("FAIL async_reset: got %b %h want all 0", bus0.out_valid, {bus0.out_a_re, bus0.out_a_im, bus0.out_b_re, bus0.out_b_im});
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        test_stream("after_reset", -1, 1'b0);
    endtask

    task automatic test_depth1();
        int ta [3] = '{0, 100, 2};
        int tb [3] = '{1, 101, 3};
        do_reset();
        for (int n = 0; n < 12; n++) begin
            apply(1, 1'b1, 1'b0, {16'(n), 16'(n * 3)}, {16'(100 + n), 16'(n * 5)});
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL depth1 valid n=%0d: got %b want %b", n, obs_v, exp_v);
            end
            if (chk_data) begin
                n_vec++;
                if ({obs_a, obs_b} !== {exp_a[1], exp_b[1]}) begin
                    n_err++; $display("FAIL depth1 data n=%0d: got %h %h want %h %h", n, obs_a, obs_b, exp_a[1], exp_b[1]);
                end
            end
            if (n >= 1 && n <= 3) begin
                n_vec++;
                if ({obs_a[31:16], obs_b[31:16]} !== {16'(ta[n-1]), 16'(tb[n-1])}) begin
                    n_err++; $display("FAIL depth1 table n=%0d: got (%0d,%0d) want (%0d,%0d)", n, obs_a[31:16], obs_b[31:16], ta[n-1], tb[n-1]);
                end
            end
        end
    endtask

    // DEPTH=64: random full-scale data, random stalls (with ignored syncs),
    // frame start on the first sample, a mid-frame resync after 4 frames.
    task automatic test_random64();
        int acc = 0;
        int cyc = 0;
        do_reset();
        while (acc < 760) begin
            if ($urandom_range(7) == 0) begin
                apply(2, 1'b0, 1'($urandom_range(1)), $urandom, $urandom);
            end else begin
                apply(2, 1'b1, (acc == 0) || (acc == 549), $urandom, $urandom);
                acc++;
            end
            cyc++;
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL rand64 valid cyc=%0d acc=%0d: got %b want %b", cyc, acc, obs_v, exp_v);
            end
            if (chk_data) begin
                n_vec++;
                if ({obs_a, obs_b} !== {exp_a[2], exp_b[2]}) begin
                    n_err++; $display("FAIL rand64 data cyc=%0d acc=%0d: got %h %h want %h %h", cyc, acc, obs_a, obs_b, exp_a[2], exp_b[2]);
                end
            end
        end
    endtask

    initial begin
        bus0.sync = 0; bus0.in_valid = 0; bus0.in_a_re = 0; bus0.in_a_im = 0; bus0.in_b_re = 0; bus0.in_b_im = 0;
        bus1.sync = 0; bus1.in_valid = 0; bus1.in_a_re = 0; bus1.in_a_im = 0; bus1.in_b_re = 0; bus1.in_b_im = 0;
        bus2.sync = 0; bus2.in_valid = 0; bus2.in_a_re = 0; bus2.in_a_im = 0; bus2.in_b_re = 0; bus2.in_b_im = 0;
        model_reset();
        test_reset();
        test_stream("stream", -1, 1'b1);
        test_stream("stall", 6, 1'b1);
        test_sync();
        test_async_reset();
        test_depth1();
        test_random64();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
